router_pkt_src: RTL and testbench

Synthesizable packet source that sits directly upstream of `router_top` and drives its `pkt_valid`/`data_in` input under `busy` flow control. Each packet it emits is framed as follows:
- a header byte `{len, dest}`;
- `len` payload bytes from an arithmetic sequence;
- one even-parity byte, with `pkt_valid` low.

It is used as a traffic generator for router bring-up and for self-checking system benches.

---
 rtl/router_pkt_src.sv | 155 +++++++++++++++
 tb/tb_router_pkt_src.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_src.sv
// Packet source feeding router_top: emits {len,dest} header, an arithmetic payload
// sequence and an even-parity trailer, all under busy back-pressure.
module router_pkt_src #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  dest,
    input  logic [5:0]  len,
    input  logic [7:0]  pld_base,
    input  logic [7:0]  pld_step,
    input  logic        inj_err,
    input  logic        busy,
    output logic        pkt_valid,
    output logic [7:0]  data_out,
    output logic        ready,
    output logic        done,
    output logic        cfg_err,
    output logic [15:0] pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [5:0]  r_len;
    logic [7:0]  r_step;
    logic [7:0]  r_acc;
    logic        r_inj;
    logic [7:0]  r_parity;
    logic [5:0]  r_index;
    logic [3:0]  r_gapCnt;
    logic        r_pktValid;
    logic [7:0]  r_data;
    logic        r_ready;
    logic        r_done;
    logic        r_cfgErr;
    logic [15:0] r_pktCount;

    logic        w_startLegal;
    logic        w_lastIdx;
    logic [7:0]  w_header;

    assign w_startLegal = (dest != 2'd3) && (len != 6'd0);
    assign w_lastIdx    = (r_index == (r_len - 6'd1));
    assign w_header     = {len, dest};

    // r_acc always holds the next payload byte, so the sequence needs only an adder
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_len      <= 6'd0;
            r_step     <= 8'd0;
            r_acc      <= 8'd0;
            r_inj      <= 1'b0;
            r_parity   <= 8'd0;
            r_index    <= 6'd0;
            r_gapCnt   <= 4'd0;
            r_pktValid <= 1'b0;
            r_data     <= 8'd0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_cfgErr   <= 1'b0;
            r_pktCount <= 16'd0;
        end else begin
            r_done   <= 1'b0;
            r_cfgErr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_startLegal) begin
                            r_len      <= len;
                            r_step     <= pld_step;
                            r_acc      <= pld_base;
                            r_inj      <= inj_err;
                            r_data     <= w_header;
                            r_parity   <= w_header;
                            r_pktValid <= 1'b1;
                            r_ready    <= 1'b0;
                            r_state    <= S_HEADER;
                        end else begin
                            r_cfgErr <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        r_data  <= r_acc;
                        r_acc   <= r_acc + r_step;
                        r_index <= 6'd0;
                        r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        r_parity <= r_parity ^ r_data;
                        r_index  <= r_index + 6'd1;
                        if (w_lastIdx) begin
                            r_data     <= r_parity ^ r_data ^ {7'b0, r_inj};
                            r_pktValid <= 1'b0;
                            r_state    <= S_PARITY;
                        end else begin
                            r_data <= r_acc;
                            r_acc  <= r_acc + r_step;
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        r_done     <= 1'b1;
                        r_pktCount <= r_pktCount + 16'd1;
                        r_data     <= 8'd0;
                        r_gapCnt   <= 4'd0;
                        if (GAP_CYCLES == 0) begin
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gapCnt == GAP_LAST) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 4'd1;
                    end
                end
                default: begin
                    r_pktValid <= 1'b0;
                    r_data     <= 8'd0;
                    r_ready    <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign pkt_valid = r_pktValid;
    assign data_out  = r_data;
    assign ready     = r_ready;
    assign done      = r_done;
    assign cfg_err   = r_cfgErr;
    assign pkt_count = r_pktCount;

endmodule

// File: tb/tb_router_pkt_src.sv
// Scoreboard bench for router_pkt_src: expected frames are queued at start time and
// compared byte by byte as the source hands them to the router.
module tb_router_pkt_src;

    localparam int GAP = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  dest;
    logic [5:0]  len;
    logic [7:0]  pld_base;
    logic [7:0]  pld_step;
    logic        inj_err;
    logic        busy;
    logic        pkt_valid;
    logic [7:0]  data_out;
    logic        ready;
    logic        done;
    logic        cfg_err;
    logic [15:0] pkt_count;

    typedef struct {
        logic [7:0] data;
        bit         isHeader;
        bit         isParity;
    } expT;

    expT expQ[$];
    int  checkCount = 0;
    int  passCount = 0;
    int  cycleCnt = 0;
    int  validCount = 0;
    int  lastParityEdge = 0;
    int  lastGap = -1;
    bit  pendingParity = 1'b0;

    router_pkt_src #(.GAP_CYCLES(GAP)) dut (
        .clock(clock),
        .resetn(resetn),
        .start(start),
        .dest(dest),
        .len(len),
        .pld_base(pld_base),
        .pld_step(pld_step),
        .inj_err(inj_err),
        .busy(busy),
        .pkt_valid(pkt_valid),
        .data_out(data_out),
        .ready(ready),
        .done(done),
        .cfg_err(cfg_err),
        .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Bytes are popped on the falling edge before the rising edge that accepts them
    always @(negedge clock) begin : monitor
        expT e;
        if (resetn) begin
            if (pkt_valid) validCount++;
            if (pendingParity) begin
                if (!busy) begin
                    e = expQ.pop_front();
                    checkOutput("parityByte", data_out, e.data);
                    checkOutput("parityValid", pkt_valid, 1'b0);
                    pendingParity = 1'b0;
                    lastParityEdge = cycleCnt + 1;
                end
            end else if (pkt_valid && !busy) begin
                if (expQ.size() == 0) begin
                    checkOutput("sbDepth", expQ.size(), 1);
                end else begin
                    e = expQ.pop_front();
                    if (e.isHeader) begin
                        lastGap = cycleCnt - lastParityEdge;
                        checkOutput("header", data_out, e.data);
                    end else begin
                        checkOutput("payload", data_out, e.data);
                    end
                    if (expQ.size() > 0 && expQ[0].isParity) pendingParity = 1'b1;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] d, input logic [5:0] l, input logic [7:0] b,
                                 input logic [7:0] s, input logic inj);
        expT        e;
        logic [7:0] par;
        int         budget;
        @(posedge clock); #1;
        e.data = {l, d};
        e.isHeader = 1'b1;
        e.isParity = 1'b0;
        expQ.push_back(e);
        par = e.data;
        for (int i = 0; i < int'(l); i++) begin
            e.data = 8'(b + i * s);
            e.isHeader = 1'b0;
            expQ.push_back(e);
            par ^= e.data;
        end
        e.data = par ^ {7'b0, inj};
        e.isHeader = 1'b0;
        e.isParity = 1'b1;
        expQ.push_back(e);
        dest = d;
        len = l;
        pld_base = b;
        pld_step = s;
        inj_err = inj;
        start = 1'b1;
        budget = 300;
        while (!ready && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        if (!ready) checkOutput("readyTimeout", ready, 1'b1);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int expCount);
        int budget;
        bit seen;
        budget = 400;
        seen = 1'b0;
        while (!seen && budget > 0) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            budget--;
        end
        checkOutput("doneSeen", seen, 1'b1);
        checkOutput("pktCount", pkt_count, expCount);
        @(negedge clock);
        checkOutput("donePulse", done, 1'b0);
        checkOutput("sbEmpty", expQ.size(), 0);
    endtask

    task automatic waitIdle();
        int budget;
        budget = 50;
        @(posedge clock); #1;
        while (!ready && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        checkOutput("idleReady", ready, 1'b1);
    endtask

    task automatic waitByte(input logic [7:0] val);
        int budget;
        budget = 200;
        while (!(pkt_valid && data_out == val) && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        checkOutput("reachByte", data_out, val);
    endtask

    task automatic badStart(input logic [1:0] d, input logic [5:0] l, input logic [15:0] cnt);
        dest = d;
        len = l;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        checkOutput("cfgErrPulse", cfg_err, 1'b1);
        checkOutput("cfgReady", ready, 1'b1);
        checkOutput("cfgNoValid", pkt_valid, 1'b0);
        @(posedge clock); #1;
        checkOutput("cfgErrClear", cfg_err, 1'b0);
        checkOutput("cfgCount", pkt_count, cnt);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        dest = 2'd0;
        len = 6'd0;
        pld_base = 8'd0;
        pld_step = 8'd0;
        inj_err = 1'b0;
        busy = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rstValid", pkt_valid, 1'b0);
        checkOutput("rstData", data_out, 8'h00);
        checkOutput("rstReady", ready, 1'b1);
        checkOutput("rstDone", done, 1'b0);
        checkOutput("rstCfgErr", cfg_err, 1'b0);
        checkOutput("rstCount", pkt_count, 16'd0);
        resetn = 1'b1;

        $display("[TB] basic packet");
        validCount = 0;
        applyStimulus(2'd2, 6'd16, 8'h00, 8'h02, 1'b0);
        waitDone(1);
        checkOutput("basicValidCycles", validCount, 17);

        $display("[TB] back-to-back packets");
        applyStimulus(2'd0, 6'd14, 8'h00, 8'h02, 1'b0);
        applyStimulus(2'd1, 6'd17, 8'h00, 8'h02, 1'b0);
        waitDone(3);
        checkOutput("gapTiming", lastGap, GAP + 1);

        $display("[TB] illegal starts");
        waitIdle();
        badStart(2'd3, 6'd5, 16'd3);
        badStart(2'd1, 6'd0, 16'd3);

        $display("[TB] stall mid-payload");
        validCount = 0;
        applyStimulus(2'd2, 6'd16, 8'h00, 8'h02, 1'b0);
        waitByte(8'h0A);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checkOutput("stallHold", data_out, 8'h0A);
            checkOutput("stallValid", pkt_valid, 1'b1);
        end
        busy = 1'b0;
        waitDone(4);
        checkOutput("stallValidCycles", validCount, 20);

        $display("[TB] parity error injection");
        applyStimulus(2'd2, 6'd16, 8'h00, 8'h02, 1'b1);
        waitDone(5);

        $display("[TB] maximum length with wrapping payload");
        applyStimulus(2'd1, 6'd63, 8'hF0, 8'h07, 1'b0);
        waitDone(6);

        $display("[TB] reset mid-packet");
        applyStimulus(2'd0, 6'd20, 8'h00, 8'h02, 1'b0);
        waitByte(8'h0E);
        resetn = 1'b0;
        expQ.delete();
        pendingParity = 1'b0;
        #1;
        checkOutput("midRstValid", pkt_valid, 1'b0);
        checkOutput("midRstData", data_out, 8'h00);
        checkOutput("midRstReady", ready, 1'b1);
        checkOutput("midRstCount", pkt_count, 16'd0);
        checkOutput("midRstDone", done, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        applyStimulus(2'd1, 6'd5, 8'h10, 8'h03, 1'b0);
        waitDone(1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
